cpu_alu_seq: RTL
================

// Module: cpu_alu_seq
// PURPOSE
//  Microsequencer that drives the 6502 ALU for the NES core. Fetches opcodes and operands over a
//  simple memory bus and decodes group-1 ALU ops plus a few control ops. Computes effective
//  addresses, presents A/B/mode/P to the external ALU, and writes result and flags back to A/X/Y/P.
//  Sits between the memory arbiter and the combinational ALU.
// PARAMETERS
//  RESET_PC  16'hC000  PC value loaded on reset (vector fetch out of scope)
//  RESET_P   8'h20     P value loaded on reset
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  mem_addr   out  16  memory address; read data returns on mem_din one cycle later
//  mem_din    in   8   read data for the address issued in the previous cycle
//  mem_dout   out  8   write data, valid while mem_we=1
//  mem_we     out  1   write strobe, one cycle per store
//  alu_a      out  8   ALU operand A
//  alu_b      out  8   ALU operand B
//  alu_mode   out  4   0 ORA,1 AND,2 EOR,3 ADC,4 STA,5 LDA,6 CMP,7 SBC,8 ADD (EA calc)
//  alu_p      out  8   current P to the ALU
//  alu_res    in   8   ALU result
//  alu_flag   in   8   ALU new flags (NV-BDIZC)
//  halt       out  1   high once an unsupported opcode is decoded; cleared only by rst
//  reg_a/x/y  out  8   architectural registers (debug/verification)
//  reg_p      out  8   status register
//  pc         out  16  program counter
// BEHAVIOUR
//  - Reset: state=FETCH, pc=RESET_PC, A=X=Y=0, P=RESET_P, halt=0. mem_we gated by ~rst, so 0 in the reset cycle.
//  - rst mid-instruction aborts at once. No partial writeback; a pending store is not issued.
//  - Supported opcodes (cc=01): aaa→alu_mode directly; bbb: 010 #imm, 001 zp, 101 zp,X, 011 abs, 111 abs,X.
//    #imm with STA is unsupported. Others: A2 LDX#, A0 LDY#, 4C JMP abs, 18 CLC, 38 SEC, EA NOP.
//    Any other opcode → HALT.
//  - States, one per cycle; mem_addr/mem_we are combinational from state:
//    FETCH : addr=pc, pc+=1 → DECODE
//    DECODE: IR<=din. Implied ops: update P[0] (CLC 0, SEC 1) → FETCH. Unsupported → HALT.
//            Otherwise addr=pc, pc+=1 → LO
//    LO    : #imm: ALU B=din, writeback → FETCH. zp: EA={8'h00,din} → READ, or INDEX for zp,X.
//            abs/JMP: EAlo<=din, addr=pc, pc+=1 → HI
//    HI    : JMP: pc<={din,EAlo} → FETCH. Else EAhi<=din → INDEX (abs,X) or READ
//    INDEX : alu_mode=8, alu_a=EAlo, alu_b=X. EAlo<=alu_res.
//            abs,X: EAhi+=alu_flag[0]. zp,X: EAhi stays 00 (page-0 wrap) → READ
//    READ  : addr=EA. STA: mem_we=1, mem_dout=A → FETCH. Else → EXEC
//    EXEC  : alu_mode=aaa, alu_a=A, alu_b=din, alu_p=P. A<=alu_res unless CMP; P<=alu_flag → FETCH
//    HALT  : no bus activity, mem_we=0, registers frozen; exit only via rst
//  - Writeback: A<=alu_res except CMP and STA. LDX#/LDY# use mode 5 and write X/Y.
//    P<=alu_flag for every ALU op except the INDEX add.
//  - ALU flags are taken as delivered; the sequencer never edits them.
//  - Cycles: implied 2, #imm 3, JMP 4, STA zp 4, zp 5, STA abs/zp,X 5, zp,X/abs 6, STA abs,X 6, abs,X 7.
//  - All 16-bit PC/EA arithmetic wraps mod 2^16. pc FFFF+1 = 0000.
//  - Idle outputs: alu_mode=4 (pass-through), alu_a=A, alu_b=0, mem_dout=A.
// STRUCTURE
//  - Package cpu_pkg: ALU mode constants (ALU_ORA..ALU_ADD), state encoding, opcode constants
//    (OP_JMP, OP_LDX_I, OP_LDY_I, OP_CLC, OP_SEC, OP_NOP), addressing-mode codes.
//  - Sub-module cpu_opdec (combinational): IR → {alu_mode, addr_mode, is_store, is_cmp, dst_sel, illegal}.
//  - ALU is instantiated beside this block at the core level, not inside it.
// TESTING
//  1. A9 80 at C000 → after 3 cycles A=80, P[7]=1, P[1]=0, pc=C002.
//  2. A9 01, 38, 69 7F → A=81, V=1, C=0, N=1; CMP C9 81 afterwards leaves A=81.
//  3. A=5A, 8D 34 12 → in cycle 5 mem_addr=1234, mem_we=1, mem_dout=5A, exactly one cycle.
//  4. A2 FF, B5 80, mem[007F]=3C → READ addr=007F (zp wrap), A=3C.
//  5. A2 01, BD FF 12, mem[1300]=77 → READ addr=1300 (carry to EAhi), A=77, 7 cycles.
//  6. 4C 00 C0 → next FETCH addr=C000. Opcode 02 → halt=1, bus idle.
//     rst during STA's HI state → no write issued; pc=RESET_PC, halt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the 6502 ALU microsequencer
package cpu_pkg;

  localparam logic [3:0] ALU_ORA = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_EOR = 4'd2;
  localparam logic [3:0] ALU_ADC = 4'd3;
  localparam logic [3:0] ALU_STA = 4'd4;
  localparam logic [3:0] ALU_LDA = 4'd5;
  localparam logic [3:0] ALU_CMP = 4'd6;
  localparam logic [3:0] ALU_SBC = 4'd7;
  localparam logic [3:0] ALU_ADD = 4'd8;

  localparam logic [7:0] OP_JMP   = 8'h4C;
  localparam logic [7:0] OP_LDX_I = 8'hA2;
  localparam logic [7:0] OP_LDY_I = 8'hA0;
  localparam logic [7:0] OP_CLC   = 8'h18;
  localparam logic [7:0] OP_SEC   = 8'h38;
  localparam logic [7:0] OP_NOP   = 8'hEA;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_LO, ST_HI, ST_INDEX, ST_READ, ST_EXEC, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    AM_IMP, AM_IMM, AM_ZP, AM_ZPX, AM_ABS, AM_ABSX, AM_JMP
  } addr_mode_e;

  typedef enum logic [1:0] {
    DST_NONE, DST_A, DST_X, DST_Y
  } dst_e;

endpackage

// File: rtl/cpu_alu_seq_if.sv
// rtl/cpu_alu_seq_if.sv - memory bus and ALU operand/result bundle
interface cpu_alu_seq_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_mode;
  logic [7:0]  alu_p;
  logic [7:0]  alu_res;
  logic [7:0]  alu_flag;

  modport master (
    output mem_addr, mem_dout, mem_we, alu_a, alu_b, alu_mode, alu_p,
    input  mem_din, alu_res, alu_flag
  );

  modport slave (
    input  mem_addr, mem_dout, mem_we, alu_a, alu_b, alu_mode, alu_p,
    output mem_din, alu_res, alu_flag
  );
endinterface

// File: rtl/cpu_opdec.sv
// rtl/cpu_opdec.sv - combinational opcode decoder for group-1 ALU ops and a few control ops
module cpu_opdec
  import cpu_pkg::*;
(
  input  logic [7:0]  ir,
  output logic [3:0]  alu_mode,
  output addr_mode_e  addr_mode,
  output logic        is_store,
  output logic        is_cmp,
  output dst_e        dst_sel,
  output logic        illegal
);

  always_comb begin
    alu_mode  = ALU_STA;
    addr_mode = AM_IMP;
    is_store  = 1'b0;
    is_cmp    = 1'b0;
    dst_sel   = DST_NONE;
    illegal   = 1'b0;
    if (ir[1:0] == 2'b01) begin
      // aaa maps straight onto the ALU mode encoding
      alu_mode = {1'b0, ir[7:5]};
      is_store = (ir[7:5] == 3'b100);
      is_cmp   = (ir[7:5] == 3'b110);
      dst_sel  = (ir[7:5] == 3'b100) ? DST_NONE : DST_A;
      case (ir[4:2])
        3'b010: begin
          addr_mode = AM_IMM;
          illegal   = (ir[7:5] == 3'b100);
        end
        3'b001:  addr_mode = AM_ZP;
        3'b101:  addr_mode = AM_ZPX;
        3'b011:  addr_mode = AM_ABS;
        3'b111:  addr_mode = AM_ABSX;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (ir)
        OP_LDX_I: begin
          alu_mode  = ALU_LDA;
          addr_mode = AM_IMM;
          dst_sel   = DST_X;
        end
        OP_LDY_I: begin
          alu_mode  = ALU_LDA;
          addr_mode = AM_IMM;
          dst_sel   = DST_Y;
        end
        OP_JMP:                   addr_mode = AM_JMP;
        OP_CLC, OP_SEC, OP_NOP:   addr_mode = AM_IMP;
        default:                  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// rtl/cpu_alu_seq.sv - microsequencer fetching/decoding 6502 ops and driving an external ALU
module cpu_alu_seq
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'hC000,
  parameter logic [7:0]  RESET_P  = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  cpu_alu_seq_if.master    bus,
  output logic             halt,
  output logic [7:0]       reg_a,
  output logic [7:0]       reg_x,
  output logic [7:0]       reg_y,
  output logic [7:0]       reg_p,
  output logic [15:0]      pc
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ea_q, ea_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d, ir_q, ir_d;

  logic [15:0] mem_addr;
  logic [7:0]  mem_dout, alu_a, alu_b, alu_p;
  logic [3:0]  alu_mode;
  logic        we_raw, wb;

  logic [7:0]  dec_ir;
  logic [3:0]  dec_alu_mode;
  addr_mode_e  dec_am;
  logic        dec_is_store, dec_is_cmp, dec_illegal;
  dst_e        dec_dst;

  // The opcode is still on the read bus during DECODE; IR holds it afterwards
  assign dec_ir = (state_q == ST_DECODE) ? bus.mem_din : ir_q;

  cpu_opdec u_opdec (
    .ir        (dec_ir),
    .alu_mode  (dec_alu_mode),
    .addr_mode (dec_am),
    .is_store  (dec_is_store),
    .is_cmp    (dec_is_cmp),
    .dst_sel   (dec_dst),
    .illegal   (dec_illegal)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ea_d     = ea_q;
    a_d      = a_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    ir_d     = ir_q;
    mem_addr = 16'h0000;
    mem_dout = a_q;
    we_raw   = 1'b0;
    alu_mode = ALU_STA;
    alu_a    = a_q;
    alu_b    = 8'h00;
    alu_p    = p_q;
    wb       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_addr = pc_q;
        pc_d     = pc_q + 16'd1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d = bus.mem_din;
        if (dec_illegal) begin
          state_d = ST_HALT;
        end else if (dec_am == AM_IMP) begin
          if (bus.mem_din == OP_CLC) p_d[0] = 1'b0;
          else if (bus.mem_din == OP_SEC) p_d[0] = 1'b1;
          state_d = ST_FETCH;
        end else begin
          mem_addr = pc_q;
          pc_d     = pc_q + 16'd1;
          state_d  = ST_LO;
        end
      end
      ST_LO: begin
        case (dec_am)
          AM_IMM: begin
            alu_mode = dec_alu_mode;
            alu_b    = bus.mem_din;
            wb       = 1'b1;
            state_d  = ST_FETCH;
          end
          AM_ZP: begin
            ea_d    = {8'h00, bus.mem_din};
            state_d = ST_READ;
          end
          AM_ZPX: begin
            ea_d    = {8'h00, bus.mem_din};
            state_d = ST_INDEX;
          end
          default: begin
            ea_d[7:0] = bus.mem_din;
            mem_addr  = pc_q;
            pc_d      = pc_q + 16'd1;
            state_d   = ST_HI;
          end
        endcase
      end
      ST_HI: begin
        if (dec_am == AM_JMP) begin
          pc_d    = {bus.mem_din, ea_q[7:0]};
          state_d = ST_FETCH;
        end else begin
          ea_d[15:8] = bus.mem_din;
          state_d    = (dec_am == AM_ABSX) ? ST_INDEX : ST_READ;
        end
      end
      ST_INDEX: begin
        // zp,X keeps EAhi at 00 so the index wraps inside page zero
        alu_mode  = ALU_ADD;
        alu_a     = ea_q[7:0];
        alu_b     = x_q;
        ea_d[7:0] = bus.alu_res;
        if (dec_am == AM_ABSX) ea_d[15:8] = ea_q[15:8] + {7'b0, bus.alu_flag[0]};
        state_d   = ST_READ;
      end
      ST_READ: begin
        mem_addr = ea_q;
        if (dec_is_store) begin
          we_raw  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_mode = dec_alu_mode;
        alu_b    = bus.mem_din;
        wb       = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
    if (wb) begin
      p_d = bus.alu_flag;
      case (dec_dst)
        DST_A:   if (!dec_is_cmp) a_d = bus.alu_res;
        DST_X:   x_d = bus.alu_res;
        DST_Y:   y_d = bus.alu_res;
        default: a_d = a_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ea_q    <= 16'h0000;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      p_q     <= RESET_P;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ea_q    <= ea_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.mem_addr = mem_addr;
  assign bus.mem_dout = mem_dout;
  assign bus.mem_we   = we_raw & ~rst;
  assign bus.alu_a    = alu_a;
  assign bus.alu_b    = alu_b;
  assign bus.alu_mode = alu_mode;
  assign bus.alu_p    = alu_p;

  assign halt  = (state_q == ST_HALT);
  assign reg_a = a_q;
  assign reg_x = x_q;
  assign reg_y = y_q;
  assign reg_p = p_q;
  assign pc    = pc_q;

endmodule
